// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller for the 5-stage LEGv8 core: load-use stalls,
// taken-branch flushes, data-memory freezes with timeout, and perf counters.
module hazard_sequencer #(
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int              TO_W      = $clog2(MEM_TIMEOUT + 1);
    localparam int              LU_W      = 3;
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
    localparam logic [LU_W-1:0] LU_INIT   = LU_W'(LOAD_LAT - 1);
    localparam logic [LU_W-1:0] LU_ONE    = LU_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit              MULTI_LAT = (LOAD_LAT > 1);

    state_t          state, state_nxt;
    logic [LU_W-1:0] lu_cnt, lu_cnt_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            err_nxt;
    logic            stall_inc;
    logic            flush_inc;
    logic            run_eval;
    logic            load_use;

    // XZR is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_memread && (ex_rd != 5'd31) &&
                      ((id_rn == ex_rd) || (id_uses_rm && (id_rm == ex_rd)));

    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= RUN;
            lu_cnt          <= '0;
            to_cnt          <= '0;
            mem_timeout_err <= 1'b0;
            stall_cycles    <= '0;
            flush_events    <= '0;
        end else begin
            state           <= state_nxt;
            lu_cnt          <= lu_cnt_nxt;
            to_cnt          <= to_cnt_nxt;
            mem_timeout_err <= err_nxt;
            if (stall_inc && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (flush_inc && (flush_events != CNT_MAX)) begin
                flush_events <= flush_events + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        lu_cnt_nxt  = lu_cnt;
        to_cnt_nxt  = to_cnt;
        err_nxt     = mem_timeout_err;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        run_eval    = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;

        case (state)
            RUN: begin
                run_eval = 1'b1;
            end
            LU_STALL: begin
                // Busy and branch take over exactly as in RUN; otherwise keep stalling.
                if (dmem_busy || mem_branch_taken) begin
                    run_eval = 1'b1;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                    if (lu_cnt <= LU_ONE) begin
                        state_nxt  = RUN;
                        lu_cnt_nxt = '0;
                    end else begin
                        lu_cnt_nxt = lu_cnt - LU_ONE;
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    stall_inc  = 1'b1;
                    if (to_cnt < TO_MAX) begin
                        to_cnt_nxt = to_cnt + TO_ONE;
                    end
                    if (to_cnt_nxt >= TO_MAX) begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    // Exit cycle behaves as a normal RUN cycle so held branches/hazards are honoured.
                    state_nxt  = RUN;
                    to_cnt_nxt = '0;
                    run_eval   = 1'b1;
                end
            end
            default: begin
                state_nxt  = RUN;
                lu_cnt_nxt = '0;
                to_cnt_nxt = '0;
            end
        endcase

        if (run_eval) begin
            if (dmem_busy) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
                stall_inc  = 1'b1;
                state_nxt  = MEM_WAIT;
                lu_cnt_nxt = '0;
                to_cnt_nxt = TO_ONE;
                if (TO_ONE >= TO_MAX) begin
                    err_nxt = 1'b1;
                end
            end else if (mem_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                flush_inc   = 1'b1;
                state_nxt   = RUN;
                lu_cnt_nxt  = '0;
            end else if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                stall_inc   = 1'b1;
                if (MULTI_LAT) begin
                    state_nxt  = LU_STALL;
                    lu_cnt_nxt = LU_INIT;
                end
            end
        end

        // Outputs are forced to their RUN values while reset is held.
        if (!reset_n) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_bubble = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            pipe_hold   = 1'b0;
        end
    end

endmodule
